// File: rtl/mbscore_fetch.sv
// Instruction-fetch stage for the MBScore multicycle controller.
// Holds PC and IR, runs a req/ack fetch against a variable-latency instruction
// memory, and applies the controller's sequencing strobes to form the next PC.
// A misaligned target or a memory that never answers parks the stage in a
// sticky error state that only reset clears.
module mbscore_fetch #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0,
    parameter logic [7:0]            TIMEOUT    = 8'd255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_inst_re,
    input  logic                  i_next,
    input  logic                  i_jal_or_j,
    input  logic                  i_beq_or_bne,
    input  logic                  i_br_cond,
    input  logic                  i_jr,
    input  logic [ADDR_WIDTH-1:0] i_jr_target,
    input  logic                  i_hlt,
    input  logic                  i_resume,
    input  logic [DATA_WIDTH-1:0] i_imem_rdata,
    input  logic                  i_imem_ack,
    output logic                  o_imem_req,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [DATA_WIDTH-1:0] o_inst,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [ADDR_WIDTH-1:0] o_pc_plus4,
    output logic                  o_inst_valid,
    output logic                  o_fetch_stall,
    output logic                  o_fetch_err,
    output logic                  o_halted
);

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_HALT = 2'd2,
        F_ERR  = 2'd3
    } fetch_state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(3'd4);

    // Branch displacement: sign-extended 16-bit immediate scaled to bytes.
    function automatic logic [ADDR_WIDTH-1:0] branch_offset(input logic [DATA_WIDTH-1:0] ir);
        return {{(ADDR_WIDTH-18){ir[15]}}, ir[15:0], 2'b00};
    endfunction

    fetch_state_t          r_state;
    fetch_state_t          w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_pc_plus4;
    logic [ADDR_WIDTH-1:0] r_imem_addr;
    logic [DATA_WIDTH-1:0] r_inst;
    logic                  r_inst_valid;
    logic                  r_imem_req;
    logic                  r_fetch_stall;
    logic                  r_fetch_err;
    logic                  r_halted;
    logic                  r_flush;
    logic [7:0]            r_cnt;

    logic [ADDR_WIDTH-1:0] w_pc_d;
    logic                  w_active;
    logic                  w_halt_req;
    logic                  w_misalign;
    logic                  w_pc_we;
    logic                  w_timeout;
    logic                  w_start;
    logic                  w_ack_take;
    logic                  w_err_set;
    logic                  w_keep;

    // Next-PC selection; hlt freezes the PC and wins over every other strobe.
    always_comb begin
        w_pc_d = r_pc;
        if (i_next) begin
            if (i_hlt) begin
                w_pc_d = r_pc;
            end else if (i_jr) begin
                w_pc_d = i_jr_target;
            end else if (i_jal_or_j) begin
                w_pc_d = {r_pc_plus4[ADDR_WIDTH-1:28], r_inst[25:0], 2'b00};
            end else if (i_beq_or_bne && i_br_cond) begin
                w_pc_d = r_pc_plus4 + branch_offset(r_inst);
            end else begin
                w_pc_d = r_pc_plus4;
            end
        end else begin
            w_pc_d = r_pc;
        end
    end

    // Sequencing strobes only act while the stage is idle or fetching.
    always_comb begin
        w_active   = (r_state == F_IDLE) || (r_state == F_REQ);
        w_halt_req = w_active && i_next && i_hlt;
        w_misalign = w_active && i_next && !i_hlt && (w_pc_d[1:0] != 2'b00);
        w_pc_we    = w_active && i_next && !i_hlt && (w_pc_d[1:0] == 2'b00);
        w_timeout  = (r_cnt == TIMEOUT);
    end

    // Fetch FSM next-state; halt and misalignment pre-empt any fetch activity.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_ack_take  = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            F_IDLE: begin
                if (w_halt_req) begin
                    w_state_nxt = F_HALT;
                end else if (w_misalign) begin
                    w_state_nxt = F_ERR;
                    w_err_set   = 1'b1;
                end else if (i_inst_re) begin
                    w_state_nxt = F_REQ;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = F_IDLE;
                end
            end
            F_REQ: begin
                if (w_halt_req) begin
                    w_state_nxt = F_HALT;
                end else if (w_misalign) begin
                    w_state_nxt = F_ERR;
                    w_err_set   = 1'b1;
                end else if (i_imem_ack) begin
                    w_state_nxt = F_IDLE;
                    w_ack_take  = 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt = F_ERR;
                    w_err_set   = 1'b1;
                end else begin
                    w_state_nxt = F_REQ;
                end
            end
            F_HALT: begin
                if (i_resume) begin
                    w_state_nxt = F_IDLE;
                end else begin
                    w_state_nxt = F_HALT;
                end
            end
            F_ERR: begin
                w_state_nxt = F_ERR;
            end
            default: begin
                w_state_nxt = F_ERR;
                w_err_set   = 1'b1;
            end
        endcase
    end

    // Returned data is kept only if the PC has not moved since the request.
    always_comb begin
        w_keep = w_ack_take && !r_flush && !i_next;
    end

    // State register plus state-decoded status outputs, all registered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= F_IDLE;
            r_imem_req    <= 1'b0;
            r_fetch_stall <= 1'b0;
            r_halted      <= 1'b0;
            r_fetch_err   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_imem_req    <= (w_state_nxt == F_REQ);
            r_fetch_stall <= (w_state_nxt == F_REQ);
            r_halted      <= (w_state_nxt == F_HALT);
            r_fetch_err   <= r_fetch_err | w_err_set;
        end
    end

    // Wait counter and flush flag live only for the duration of one fetch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= 8'd0;
            r_flush <= 1'b0;
        end else if ((r_state == F_REQ) && (w_state_nxt == F_REQ)) begin
            r_cnt   <= r_cnt + 8'd1;
            r_flush <= r_flush | w_pc_we;
        end else begin
            r_cnt   <= 8'd0;
            r_flush <= 1'b0;
        end
    end

    // PC and its link value move together on every accepted next.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc       <= RESET_PC;
            r_pc_plus4 <= RESET_PC + PC_STEP;
        end else if (w_pc_we) begin
            r_pc       <= w_pc_d;
            r_pc_plus4 <= w_pc_d + PC_STEP;
        end else begin
            r_pc       <= r_pc;
            r_pc_plus4 <= r_pc_plus4;
        end
    end

    // Fetch address is latched at request start and held for the whole fetch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_imem_addr <= RESET_PC;
        end else if (w_start) begin
            r_imem_addr <= w_pc_d;
        end else begin
            r_imem_addr <= r_imem_addr;
        end
    end

    // IR capture; inst_valid drops whenever PC and IR stop matching.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inst       <= {DATA_WIDTH{1'b0}};
            r_inst_valid <= 1'b0;
        end else if (w_keep) begin
            r_inst       <= i_imem_rdata;
            r_inst_valid <= 1'b1;
        end else if (w_start || w_pc_we) begin
            r_inst       <= r_inst;
            r_inst_valid <= 1'b0;
        end else begin
            r_inst       <= r_inst;
            r_inst_valid <= r_inst_valid;
        end
    end

    assign o_imem_req    = r_imem_req;
    assign o_imem_addr   = r_imem_addr;
    assign o_inst        = r_inst;
    assign o_pc          = r_pc;
    assign o_pc_plus4    = r_pc_plus4;
    assign o_inst_valid  = r_inst_valid;
    assign o_fetch_stall = r_fetch_stall;
    assign o_fetch_err   = r_fetch_err;
    assign o_halted      = r_halted;

endmodule

// File: tb/tb_mbscore_fetch.sv
// Bench for mbscore_fetch: directed scenarios with literal expectations, then
// randomized strobes and memory latencies checked every cycle against a
// transaction-level model of the fetch stage.
module tb_mbscore_fetch;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_re, next, jal_or_j, beq_or_bne, br_cond, jr, hlt, resume;
    logic [31:0] jr_target;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        o_imem_req, o_inst_valid, o_fetch_stall, o_fetch_err, o_halted;
    logic [31:0] o_imem_addr, o_inst, o_pc, o_pc_plus4;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // memory responder controls
    int          lat = 0;
    int          req_age = 0;
    bit          rand_lat = 1'b0;
    bit          spur_en = 1'b0;
    bit          use_fixed = 1'b1;
    logic [31:0] fixed_rdata = 32'h0;

    // model state
    logic [31:0] m_pc, m_addr, m_inst;
    bit          m_valid, m_busy, m_halt, m_err, m_stale;
    int          m_wait;

    always #5 clk = ~clk;

    mbscore_fetch dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_inst_re    (inst_re),
        .i_next       (next),
        .i_jal_or_j   (jal_or_j),
        .i_beq_or_bne (beq_or_bne),
        .i_br_cond    (br_cond),
        .i_jr         (jr),
        .i_jr_target  (jr_target),
        .i_hlt        (hlt),
        .i_resume     (resume),
        .i_imem_rdata (imem_rdata),
        .i_imem_ack   (imem_ack),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .o_inst       (o_inst),
        .o_pc         (o_pc),
        .o_pc_plus4   (o_pc_plus4),
        .o_inst_valid (o_inst_valid),
        .o_fetch_stall(o_fetch_stall),
        .o_fetch_err  (o_fetch_err),
        .o_halted     (o_halted)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model of one clock of the fetch stage.
    task automatic model_step();
        logic [31:0] tgt;
        int          off;
        if (rst) begin
            m_pc = 32'h0; m_addr = 32'h0; m_inst = 32'h0;
            m_valid = 1'b0; m_busy = 1'b0; m_halt = 1'b0; m_err = 1'b0;
            m_stale = 1'b0; m_wait = 0;
            return;
        end
        if (m_err) return;
        if (m_halt) begin
            if (resume) m_halt = 1'b0;
            return;
        end
        if (!next || hlt) begin
            tgt = m_pc;
        end else if (jr) begin
            tgt = jr_target;
        end else if (jal_or_j) begin
            tgt = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, m_inst[25:0]} << 2);
        end else if (beq_or_bne && br_cond) begin
            off = int'($signed(m_inst[15:0]));
            tgt = m_pc + 32'd4 + 32'(off * 4);
        end else begin
            tgt = m_pc + 32'd4;
        end
        if (next && hlt) begin
            m_halt = 1'b1; m_busy = 1'b0;
            return;
        end
        if (next && (tgt % 4 != 0)) begin
            m_err = 1'b1; m_busy = 1'b0;
            return;
        end
        if (next) begin
            m_pc = tgt; m_valid = 1'b0;
            if (m_busy) m_stale = 1'b1;
        end
        if (!m_busy) begin
            if (inst_re) begin
                m_busy = 1'b1; m_addr = m_pc; m_valid = 1'b0; m_wait = 0; m_stale = 1'b0;
            end
        end else if (imem_ack) begin
            if (!m_stale) begin
                m_inst = imem_rdata; m_valid = 1'b1;
            end
            m_busy = 1'b0;
        end else if (m_wait == TIMEOUT) begin
            m_err = 1'b1; m_busy = 1'b0;
        end else begin
            m_wait++;
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", o_pc, m_pc);
            chk("pc_plus4", o_pc_plus4, m_pc + 32'd4);
            chk("imem_addr", o_imem_addr, m_addr);
            chk("inst", o_inst, m_inst);
            chk("inst_valid", 32'(o_inst_valid), 32'(m_valid));
            chk("imem_req", 32'(o_imem_req), 32'(m_busy));
            chk("fetch_stall", 32'(o_fetch_stall), 32'(m_busy));
            chk("fetch_err", 32'(o_fetch_err), 32'(m_err));
            chk("halted", 32'(o_halted), 32'(m_halt));
        end
    end

    task automatic clr();
        inst_re = 1'b0; next = 1'b0; jal_or_j = 1'b0; beq_or_bne = 1'b0;
        br_cond = 1'b0; jr = 1'b0; hlt = 1'b0; resume = 1'b0; jr_target = 32'h0;
    endtask

    // One clock: memory responder decides ack, then posedge, model, negedge.
    task automatic tick();
        logic ack;
        if (o_imem_req) begin
            if (req_age == 0 && rand_lat)
                lat = ($urandom_range(0, 149) == 0) ? 400 : int'($urandom_range(0, 4));
            ack = (req_age >= lat);
            req_age++;
        end else begin
            req_age = 0;
            ack = spur_en && ($urandom_range(0, 7) == 0);
        end
        imem_ack   = ack;
        imem_rdata = (ack && use_fixed) ? fixed_rdata : $urandom;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clr();
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_pc4", o_pc_plus4, 32'h4);
        chk("rst_inst", o_inst, 32'h0);
        chk("rst_req", 32'(o_imem_req), 32'h0);
        chk("rst_err", 32'(o_fetch_err), 32'h0);
        rst = 1'b0;

        // 1: zero-wait fetch
        lat = 0; fixed_rdata = 32'h2008_0005;
        inst_re = 1'b1; tick(); clr();
        chk("t1_req", 32'(o_imem_req), 32'h1);
        chk("t1_addr", o_imem_addr, 32'h0);
        tick();
        chk("t1_inst", o_inst, 32'h2008_0005);
        chk("t1_valid", 32'(o_inst_valid), 32'h1);
        chk("t1_pc", o_pc, 32'h0);

        // 2: sequential next, then 3-cycle memory
        next = 1'b1; tick(); clr();
        lat = 2; inst_re = 1'b1; tick(); clr();
        chk("t2_addr", o_imem_addr, 32'h4);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (!o_fetch_stall) break;
            n++;
            tick();
        end
        chk("t2_stall_cycles", 32'(n), 32'd3);

        // 3: taken and untaken branch with same-cycle refetch
        lat = 0;
        next = 1'b1; jr = 1'b1; jr_target = 32'h40; tick(); clr();
        fixed_rdata = 32'h1000_FFFE;
        inst_re = 1'b1; tick(); clr(); tick();
        chk("t3_pc", o_pc, 32'h40);
        chk("t3_inst", o_inst, 32'h1000_FFFE);
        beq_or_bne = 1'b1; br_cond = 1'b1; next = 1'b1; inst_re = 1'b1; tick(); clr();
        chk("t3_taken_addr", o_imem_addr, 32'h3C);
        tick();
        next = 1'b1; jr = 1'b1; jr_target = 32'h40; tick(); clr();
        beq_or_bne = 1'b1; br_cond = 1'b0; next = 1'b1; inst_re = 1'b1; tick(); clr();
        chk("t3_untaken_addr", o_imem_addr, 32'h44);
        tick();

        // 4: J target, then misaligned JR
        next = 1'b1; jr = 1'b1; jr_target = 32'h1000_0010; tick(); clr();
        fixed_rdata = 32'h0800_0100;
        inst_re = 1'b1; tick(); clr(); tick();
        next = 1'b1; jal_or_j = 1'b1; tick(); clr();
        chk("t4_jpc", o_pc, 32'h1000_0400);
        next = 1'b1; jr = 1'b1; jr_target = 32'h22; inst_re = 1'b1; tick(); clr();
        chk("t4_err", 32'(o_fetch_err), 32'h1);
        chk("t4_noreq", 32'(o_imem_req), 32'h0);
        chk("t4_pc_held", o_pc, 32'h1000_0400);
        do_reset();

        // 5: timeout, then reset in the middle of a wait
        lat = 1000;
        inst_re = 1'b1; tick(); clr();
        n = 0;
        for (int k = 0; k < 300; k++) begin
            if (o_fetch_err) break;
            if (o_fetch_stall) n++;
            tick();
        end
        chk("t5_wait_cycles", 32'(n), 32'd256);
        chk("t5_err", 32'(o_fetch_err), 32'h1);
        chk("t5_noreq", 32'(o_imem_req), 32'h0);
        do_reset();
        inst_re = 1'b1; tick(); clr(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_req", 32'(o_imem_req), 32'h0);
        chk("t5_rst_stall", 32'(o_fetch_stall), 32'h0);
        chk("t5_rst_addr", o_imem_addr, 32'h0);
        chk("t5_rst_valid", 32'(o_inst_valid), 32'h0);
        tick();
        rst = 1'b0;

        // 6: halt and resume
        lat = 0;
        next = 1'b1; jr = 1'b1; jr_target = 32'h80; tick(); clr();
        hlt = 1'b1; next = 1'b1; inst_re = 1'b1; tick(); clr();
        chk("t6_halted", 32'(o_halted), 32'h1);
        chk("t6_pc", o_pc, 32'h80);
        chk("t6_noreq", 32'(o_imem_req), 32'h0);
        inst_re = 1'b1; tick(); clr();
        chk("t6_ignored", 32'(o_imem_req), 32'h0);
        resume = 1'b1; tick(); clr();
        chk("t6_resumed", 32'(o_halted), 32'h0);
        inst_re = 1'b1; tick(); clr();
        chk("t6_refetch_addr", o_imem_addr, 32'h80);
        tick();

        // randomized phase
        rand_lat = 1'b1; spur_en = 1'b1; use_fixed = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (m_err || $urandom_range(0, 299) == 0) begin
                clr();
                do_reset();
            end else begin
                inst_re    = $urandom_range(0, 1) == 0;
                next       = $urandom_range(0, 4) == 0;
                hlt        = $urandom_range(0, 9) == 0;
                jr         = $urandom_range(0, 3) == 0;
                jal_or_j   = $urandom_range(0, 3) == 0;
                beq_or_bne = $urandom_range(0, 2) == 0;
                br_cond    = $urandom_range(0, 1) == 0;
                resume     = $urandom_range(0, 3) == 0;
                jr_target  = $urandom;
                if ($urandom_range(0, 19) != 0) jr_target[1:0] = 2'b00;
                tick();
            end
        end
        clr();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
